// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed little-endian
// byte stream into 32-bit word writes, holding the core in reset until done.
module imem_loader #(
  parameter int PROG_SIZE = 648,
  parameter int ADDR_W    = $clog2(PROG_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [7:0]       len_lo;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_q;      // first three bytes of the word in flight, oldest lowest
  logic [ADDR_W:0]  word_idx;
  logic [ADDR_W:0]  last_idx;
  logic             hs;
  logic [15:0]      n_hdr;
  logic             len_bad;
  logic             word_end;
  logic             word_last;
  logic [31:0]      word_nxt;

  assign hs        = in_valid & in_ready;
  assign n_hdr     = {in_data, len_lo};
  assign len_bad   = (n_hdr == 16'd0) || (n_hdr > 16'(PROG_SIZE));
  assign word_end  = (byte_idx == 2'd3);
  assign word_last = (word_idx == last_idx);
  assign word_nxt  = {in_data, asm_q};

  assign words_loaded = word_idx;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_LEN0: begin
        in_ready = 1'b1;
        if (hs) state_nxt = S_LEN1;
      end
      S_LEN1: begin
        in_ready = 1'b1;
        if (hs) state_nxt = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (hs && word_end && word_last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_DONE;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_LEN0;
    endcase
    if (rst) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LEN0;
      len_lo   <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      word_idx <= '0;
      last_idx <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      core_rst <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= 1'b0;
      case (state)
        S_LEN0: if (hs) len_lo <= in_data;
        S_LEN1: begin
          if (hs) begin
            last_idx <= n_hdr[ADDR_W:0] - W_ONE;
            error    <= len_bad;
            byte_idx <= '0;
            word_idx <= '0;
          end
        end
        S_DATA: begin
          if (hs) begin
            byte_idx <= byte_idx + 2'd1;
            asm_q    <= {in_data, asm_q[23:8]};
            if (word_end) begin
              we       <= 1'b1;
              waddr    <= word_idx[ADDR_W-1:0];
              wdata    <= word_nxt;
              word_idx <= word_idx + W_ONE;
            end
          end
        end
        // first edge in DONE is the end of the final write cycle
        S_DONE: begin
          done     <= 1'b1;
          core_rst <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic, gapped, bad-length, max-size and
// mid-load reset scenarios, with a write monitor collecting every we pulse.
module tb_imem_loader;

  localparam int PROG_SIZE = 648;
  localparam int ADDR_W    = $clog2(PROG_SIZE);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              core_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] q_addr[$];
  logic [31:0]       q_data[$];
  logic              we_prev = 1'b0;
  int                dbl_we  = 0;

  imem_loader #(.PROG_SIZE(PROG_SIZE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .core_rst(core_rst), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      q_addr.push_back(waddr);
      q_data.push_back(wdata);
      if (we_prev) dbl_we++;
    end
    we_prev = we;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) tick();
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit chk_vals);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (chk_vals) begin
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_waddr_wdata", {22'(waddr), 10'd0} | wdata, 32'd0);
      end
    end
    rst = 1'b0;
    #1;
    q_addr.delete();
    q_data.delete();
    dbl_we = 0;
  endtask

  task automatic check_basic_writes(input string tag);
    chk({tag, "_nwr"}, 32'(q_addr.size()), 32'd2);
    if (q_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(q_addr[0]), 32'd0);
      chk({tag, "_d0"}, q_data[0], 32'h00a00513);
      chk({tag, "_a1"}, 32'(q_addr[1]), 32'd1);
      chk({tag, "_d1"}, q_data[1], 32'h00100593);
    end
    chk({tag, "_dbl_we"}, 32'(dbl_we), 32'd0);
  endtask

  logic [7:0] basic_bytes[8] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05};

  initial begin
    int bad;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    // reset values, then ready once released
    do_reset(1'b1);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // basic load, one byte per cycle
    for (int i = 0; i < 6; i++) send(basic_bytes[i], 0);
    chk("basic_we0", 32'(we), 32'd1);
    chk("basic_waddr0", 32'(waddr), 32'd0);
    chk("basic_wdata0", wdata, 32'h00a00513);
    send(8'h93, 0);
    chk("basic_we0_len", 32'(we), 32'd0);
    send(8'h05, 0);
    send(8'h10, 0);
    send(8'h00, 0);
    chk("basic_we1", 32'(we), 32'd1);
    chk("basic_waddr1", 32'(waddr), 32'd1);
    chk("basic_wdata1", wdata, 32'h00100593);
    chk("basic_done_not_yet", 32'(done), 32'd0);
    tick();
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_core_rst", 32'(core_rst), 32'd0);
    chk("basic_words", 32'(words_loaded), 32'd2);
    chk("basic_in_ready", 32'(in_ready), 32'd0);
    check_basic_writes("basic");

    // gapped source
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) send(basic_bytes[i], $urandom_range(0, 5));
    send(8'h93, $urandom_range(0, 5));
    send(8'h05, $urandom_range(0, 5));
    send(8'h10, $urandom_range(0, 5));
    send(8'h00, $urandom_range(0, 5));
    for (int i = 0; i < 4; i++) tick();
    check_basic_writes("gap");
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_words", 32'(words_loaded), 32'd2);

    // bad length: zero
    do_reset(1'b0);
    send(8'h00, 0);
    send(8'h00, 0);
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_in_ready", 32'(in_ready), 32'd0);
    send(8'h13, 0);
    send(8'h05, 0);
    tick();
    chk("len0_core_rst", 32'(core_rst), 32'd1);
    chk("len0_nwr", 32'(q_addr.size()), 32'd0);
    chk("len0_done", 32'(done), 32'd0);

    // bad length: 649
    do_reset(1'b0);
    send(8'h89, 0);
    send(8'h02, 0);
    chk("len649_error", 32'(error), 32'd1);
    chk("len649_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) send(8'h11, 0);
    chk("len649_core_rst", 32'(core_rst), 32'd1);
    chk("len649_nwr", 32'(q_addr.size()), 32'd0);

    // maximum program, word k = k
    do_reset(1'b0);
    send(8'h88, 0);
    send(8'h02, 0);
    for (int k = 0; k < PROG_SIZE; k++) begin
      send(8'(k), 0);
      send(8'(k >> 8), 0);
      send(8'h00, 0);
      send(8'h00, 0);
    end
    chk("max_we_last", 32'(we), 32'd1);
    chk("max_waddr_last", 32'(waddr), 32'd647);
    chk("max_wdata_last", wdata, 32'h00000287);
    tick();
    chk("max_done", 32'(done), 32'd1);
    chk("max_core_rst", 32'(core_rst), 32'd0);
    chk("max_words", 32'(words_loaded), 32'(PROG_SIZE));
    chk("max_nwr", 32'(q_addr.size()), 32'(PROG_SIZE));
    bad = 0;
    for (int k = 0; k < q_addr.size(); k++)
      if (q_addr[k] !== ADDR_W'(k) || q_data[k] !== 32'(k)) bad++;
    chk("max_contents", 32'(bad), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h5a;
    #1;
    chk("max_in_ready_after", 32'(in_ready), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    chk("max_no_extra_wr", 32'(q_addr.size()), 32'(PROG_SIZE));
    chk("max_dbl_we", 32'(dbl_we), 32'd0);

    // reset mid-word, then a fresh one-word load
    do_reset(1'b0);
    send(8'h02, 0);
    send(8'h00, 0);
    for (int i = 0; i < 4; i++) send(8'h77, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    do_reset(1'b1);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    send(8'h01, 0);
    send(8'h00, 0);
    send(8'hef, 0);
    send(8'hbe, 0);
    send(8'had, 0);
    send(8'hde, 0);
    chk("mid_we", 32'(we), 32'd1);
    chk("mid_waddr", 32'(waddr), 32'd0);
    chk("mid_wdata", wdata, 32'hdeadbeef);
    tick();
    chk("mid_done", 32'(done), 32'd1);
    chk("mid_words", 32'(words_loaded), 32'd1);
    tick();
    chk("mid_nwr", 32'(q_addr.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Fills the instruction memory from a byte stream at boot, replacing the simulation-only file preload.
- Sits between a byte source (UART receiver or bench driver) and the instruction memory write port.
- Holds the core in reset until the whole program is written, then releases it.

Parameters:
- PROG_SIZE, 648, instruction memory depth in 32-bit words; the maximum loadable program.
- ADDR_W, $clog2(PROG_SIZE), width of the word address.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte source holds a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte. A handshake occurs when in_valid and in_ready are both 1 at a rising edge.
- we  out  1  instruction memory write strobe, one cycle per word.
- waddr  out  ADDR_W  word index to write.
- wdata  out  32  word to write.
- core_rst  out  1  reset to the riscv core; held at 1 until loading completes.
- done  out  1  program fully loaded (sticky).
- error  out  1  illegal length header (sticky).
- words_loaded  out  ADDR_W+1  number of words written so far.

Behaviour:
- Stream format:
  - Bytes 0 and 1 carry the 16-bit word count N, little-endian (LSB first).
  - These are followed by 4*N instruction bytes. Each word is little-endian: its first byte goes to wdata[7:0] and its fourth to wdata[31:24].
- States: LEN0 -> LEN1 -> DATA -> DONE, or LEN1 -> ERR.
  - LEN0: capture the low byte of N on handshake, then go to LEN1.
  - LEN1: capture the high byte of N on handshake.
    - N == 0 or N > PROG_SIZE -> ERR.
    - Otherwise -> DATA, with word index 0 and byte index 0.
  - DATA: each handshake shifts the byte into the assembly register and increments byte index mod 4. The handshake with byte index 3 completes a word:
    - Next cycle: we=1, waddr=word index, wdata=assembled word, for exactly one cycle.
    - Word index and words_loaded increment at the edge that raises we.
    - If the completed word is word N-1, state -> DONE at that same edge.
  - DONE: in_ready=0. done rises and core_rst falls at the edge after the final we cycle, so done never overlaps the last write. Stays here until rst.
  - ERR: in_ready=0, error=1, core_rst stays 1, we is never asserted. Stays here until rst.
- in_ready is combinational from state: 1 in LEN0/LEN1/DATA, 0 in DONE/ERR, and forced to 0 while rst=1.
- The source may drop in_valid between bytes for any number of cycles; gaps do not change state and do not lengthen the we pulse. The source may also present a byte on every cycle; that is full throughput, with one word written per 4 cycles.
- Bytes presented while in_ready=0 are ignored, with no state change.
- Reset values, including rst asserted mid-load:
  - Outputs: we=0, waddr=0, wdata=0, core_rst=1, done=0, error=0, words_loaded=0.
  - State LEN0; byte and word indices 0; any partial word is discarded.
  - Memory contents already written are not cleared.
- N == PROG_SIZE is legal; the last write is to waddr=PROG_SIZE-1. waddr never wraps.

Test Plan:
- Basic load: stream 02 00, then 13 05 a0 00, then 93 05 10 00, one byte per cycle.
  - Expect we pulses at waddr 0 with 0x00a00513 and at waddr 1 with 0x00100593.
  - Expect done=1 and core_rst=0 the cycle after the second we, and words_loaded=2.
- Gapped source: same stream as the basic load, with in_valid randomly low 0-5 cycles between bytes.
  - Expect identical writes, each we exactly 1 cycle, and no extra writes.
- Bad length: header 00 00 -> error=1 one cycle after the LEN1 handshake. Header 89 02 (649) -> error=1. In both cases in_ready=0, we never asserted, core_rst stays 1.
- Max program: N=648 (88 02) with word k = k.
  - Expect the last write at waddr 647 with data 0x00000287, then done=1.
  - Bytes offered afterwards are not accepted.
- Reset mid-word: assert rst after 2 data bytes of word 1; then send 01 00 and ef be ad de.
  - Expect a single write at waddr 0 with 0xdeadbeef, then done.
- Reset values: hold rst for 3 cycles at any state.
  - Expect in_ready=0, we=0, core_rst=1, done=0, error=0, words_loaded=0 during reset.
  - Expect in_ready=1 the cycle after rst falls.
